// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUPSIZE-bit lookahead group per
// stage, a global stall on output backpressure, and registered result flags.
module pipelined_cla_adder #(
  parameter int WIDTH     = 32,
  parameter int GROUPSIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_g,
  output logic             out_p
);

  localparam int NGROUPS = WIDTH / GROUPSIZE;

  logic advance;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_stage
    localparam int LO  = k * GROUPSIZE;
    localparam int REM = WIDTH - LO;

    // Operand bits from this group upwards; the lower groups are already summed.
    logic [REM-1:0]          src_a;
    logic [REM-1:0]          src_b;
    logic                    src_v;
    logic                    src_c;
    logic [GROUPSIZE-1:0]    gen;
    logic [GROUPSIZE-1:0]    prop;
    logic [GROUPSIZE:0]      carry;
    logic [GROUPSIZE-1:0]    grp_sum;
    logic                    grp_c;
    logic                    grp_g;
    logic                    grp_p;
    logic [LO+GROUPSIZE-1:0] nxt_sum;
    logic                    nxt_g;
    logic                    nxt_p;
    logic                    v_q;
    logic                    c_q;
    logic                    g_q;
    logic                    p_q;
    logic [LO+GROUPSIZE-1:0] sum_q;

    if (k == 0) begin : g_src
      assign src_v   = in_valid;
      assign src_a   = in_a;
      assign src_b   = in_sub ? ~in_b : in_b;
      assign src_c   = in_sub | in_cin;
      assign nxt_sum = grp_sum;
      assign nxt_g   = grp_g;
      assign nxt_p   = grp_p;
    end else begin : g_src
      assign src_v   = g_stage[k-1].v_q;
      assign src_a   = g_stage[k-1].g_fwd.a_q;
      assign src_b   = g_stage[k-1].g_fwd.b_q;
      assign src_c   = g_stage[k-1].c_q;
      assign nxt_sum = {grp_sum, g_stage[k-1].sum_q};
      assign nxt_g   = grp_g | (grp_p & g_stage[k-1].g_q);
      assign nxt_p   = grp_p & g_stage[k-1].p_q;
    end

    assign gen  = src_a[GROUPSIZE-1:0] & src_b[GROUPSIZE-1:0];
    assign prop = src_a[GROUPSIZE-1:0] ^ src_b[GROUPSIZE-1:0];

    always_comb begin
      carry    = '0;
      carry[0] = src_c;
      grp_g    = 1'b0;
      for (int unsigned i = 0; i < GROUPSIZE; i++) begin
        carry[i+1] = gen[i] | (prop[i] & carry[i]);
        grp_g      = gen[i] | (prop[i] & grp_g);
      end
      grp_sum = prop ^ carry[GROUPSIZE-1:0];
      grp_c   = carry[GROUPSIZE];
      grp_p   = &prop;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        g_q   <= 1'b0;
        p_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= src_v;
        c_q   <= grp_c;
        g_q   <= nxt_g;
        p_q   <= nxt_p;
        sum_q <= nxt_sum;
      end
    end

    if (k < NGROUPS - 1) begin : g_fwd
      logic [REM-GROUPSIZE-1:0] a_q;
      logic [REM-GROUPSIZE-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= src_a[REM-1:GROUPSIZE];
          b_q <= src_b[REM-1:GROUPSIZE];
        end
      end
    end else begin : g_last
      logic zero_q;
      logic ovf_q;

      // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          zero_q <= 1'b1;
          ovf_q  <= 1'b0;
        end else if (advance) begin
          zero_q <= (nxt_sum == '0);
          ovf_q  <= grp_sum[GROUPSIZE-1] ^ src_a[REM-1] ^ src_b[REM-1] ^ grp_c;
        end
      end
    end
  end

  assign out_valid = g_stage[NGROUPS-1].v_q;
  assign out_sum   = g_stage[NGROUPS-1].sum_q;
  assign out_cout  = g_stage[NGROUPS-1].c_q;
  assign out_g     = g_stage[NGROUPS-1].g_q;
  assign out_p     = g_stage[NGROUPS-1].p_q;
  assign out_zero  = g_stage[NGROUPS-1].g_last.zero_q;
  assign out_ovf   = g_stage[NGROUPS-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=16, GROUPSIZE=4): arithmetic reference model
// with an ordered scoreboard, plus literal expectations for the corner cases.
`timescale 1ns/1ps
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        g;
    logic        p;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;
  logic        out_g;
  logic        out_p;

  int   checks = 0;
  int   errors = 0;
  int   received = 0;
  res_t exp_q[$];

  logic [15:0] va [256];
  logic [15:0] vb [256];
  logic        vc [256];
  logic        vs [256];

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(16), .GROUPSIZE(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_g(out_g), .out_p(out_p)
  );

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    logic [15:0] eb;
    logic [16:0] full;
    logic [16:0] nocin;
    eb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, eb} + {16'd0, (sub | cin)};
    nocin  = {1'b0, a} + {1'b0, eb};
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (a[15] == eb[15]) && (full[15] != a[15]);
    r.zero = (full[15:0] == 16'h0000);
    r.g    = nocin[16];
    r.p    = ((a ^ eb) == 16'hFFFF);
    return r;
  endfunction

  function automatic res_t dut_res();
    return {out_sum, out_cout, out_ovf, out_zero, out_g, out_p};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  logic prev_stall = 1'b0;
  logic prev_rst = 1'b1;
  res_t prev_out;
  always @(negedge clk) begin
    res_t now_out;
    res_t e;
    now_out = dut_res();
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("in_ready rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall && !prev_rst) begin
        chk("stall hold valid", out_valid, 1);
        chk("stall hold fields", now_out, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected output: got sum %0h with no pending bundle", out_sum);
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard result", now_out, e);
          received++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
    end
    prev_stall = out_valid && !out_ready;
    prev_rst   = rst;
    prev_out   = now_out;
  end

  // Call at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    bit acc;
    int t;
    acc = 0;
    t = 0;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    chk("send accepted", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input res_t e);
    int lat;
    chk({name, " model"}, model(a, b, cin, sub), e);
    out_ready = 1'b1;
    send(a, b, cin, sub);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    chk({name, " latency"}, lat, 4);
    chk({name, " result"}, dut_res(), e);
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n, input bit rnd);
    int idx;
    int cyc;
    int stalled;
    int base;
    int t;
    idx = 0; cyc = 0; stalled = 0; base = received;
    while (idx < n && cyc < 5000) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 5 && cyc <= 7);
      in_valid  = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      in_a = va[idx]; in_b = vb[idx]; in_cin = vc[idx]; in_sub = vs[idx];
      @(negedge clk);
      if (!in_ready) stalled++;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream accepted", idx, n);
    if (!rnd) chk("stall in_ready low cycles", stalled, 3);
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stream drained", exp_q.size(), 0);
    chk("stream outputs", received - base, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sa [8] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'h00FF, 16'hABCD, 16'h0000};
    logic [15:0] sb [8] = '{16'h0002, 16'hFFFF, 16'h7FFF, 16'h0001, 16'h4321, 16'hFF01, 16'h1234, 16'h0000};
    logic        sc [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        ss [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int quiet;

    rst = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset fields", dut_res(), {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", in_ready, 1);
    @(posedge clk); #1;

    directed("ffff+1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    directed("7fff+1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    directed("allprop",  16'h00FF, 16'hFF00, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    directed("8000-1",   16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    directed("3-5",      16'h0003, 16'h0005, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("5-3 cin1", 16'h0005, 16'h0003, 1'b1, 1'b1, {16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});

    for (int i = 0; i < 8; i++) begin
      va[i] = sa[i]; vb[i] = sb[i]; vc[i] = sc[i]; vs[i] = ss[i];
    end
    stream(8, 1'b0);

    // Two bundles, then a third presented together with reset: all must vanish.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = sa[i]; in_b = sb[i]; in_cin = sc[i]; in_sub = ss[i];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b0; in_sub = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready after mid reset", in_ready, 1);
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (!out_valid) quiet++;
    end
    chk("post-reset quiet cycles", quiet, 8);
    @(posedge clk); #1;
    directed("post-reset", 16'h1234, 16'h1111, 1'b0, 1'b0, {16'h2345, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 200; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom);
      vc[i] = 1'($urandom); vs[i] = 1'($urandom);
    end
    stream(200, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
